// File: rtl/clk_tick_gen.sv
// rtl/clk_tick_gen.sv - multi-channel programmable tick / 50% square-wave divider
// Each channel counts CLK edges against a runtime divisor and emits TICK/CLK_OUT enables.
module clk_tick_gen #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 19,
  parameter int DIV_RESET = 262144
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    EN,
  input  logic                    SYNC,
  input  logic [N_CH-1:0]         DIV_LOAD,
  input  logic [N_CH*CNT_W-1:0]   DIV_IN,
  output logic [N_CH-1:0]         TICK,
  output logic [N_CH-1:0]         CLK_OUT,
  output logic [N_CH*CNT_W-1:0]   DIV_ACTIVE
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_RESET);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W-1:0] div_shadow;
    logic             pend;
    logic             tick;
    logic             clk_out;

    logic             load;
    logic [CNT_W-1:0] din;
    logic [CNT_W-1:0] next_shadow;
    logic             next_pend;
    logic             halted;
    logic             wrap;

    assign load        = DIV_LOAD[i];
    assign din         = DIV_IN[i*CNT_W +: CNT_W];
    // A load landing on an apply edge is folded in, so the newest value wins.
    assign next_shadow = load ? din : div_shadow;
    assign next_pend   = load | pend;
    assign halted      = (div_active == '0);
    assign wrap        = !halted && (cnt == div_active - ONE);

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        cnt        <= '0;
        div_active <= DIV_RST;
        div_shadow <= DIV_RST;
        pend       <= 1'b0;
        tick       <= 1'b0;
        clk_out    <= 1'b0;
      end else begin
        tick       <= 1'b0;
        div_shadow <= next_shadow;
        pend       <= next_pend;
        if (SYNC) begin
          cnt     <= '0;
          clk_out <= 1'b0;
          if (next_pend) begin
            div_active <= next_shadow;
            pend       <= 1'b0;
          end
        end else if (halted) begin
          // A halted channel takes a new divisor straight away, EN or not.
          cnt <= '0;
          if (load) begin
            div_active <= din;
            pend       <= 1'b0;
          end
        end else if (EN) begin
          if (wrap) begin
            cnt     <= '0;
            tick    <= 1'b1;
            clk_out <= ~clk_out;
            if (next_pend) begin
              div_active <= next_shadow;
              pend       <= 1'b0;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
      end
    end

    assign TICK[i]                       = tick;
    assign CLK_OUT[i]                    = clk_out;
    assign DIV_ACTIVE[i*CNT_W +: CNT_W]  = div_active;
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// tb/tb_clk_tick_gen.sv - self-checking bench for clk_tick_gen (2 channels, 8-bit, reset divisor 4)
// A per-channel period model predicts TICK, CLK_OUT and DIV_ACTIVE after every edge.
module tb_clk_tick_gen;

  localparam int N_CH = 2;
  localparam int CNT_W = 8;
  localparam int DIV_RESET = 4;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic                  EN;
  logic                  SYNC;
  logic [N_CH-1:0]       DIV_LOAD;
  logic [N_CH*CNT_W-1:0] DIV_IN;
  logic [N_CH-1:0]       TICK;
  logic [N_CH-1:0]       CLK_OUT;
  logic [N_CH*CNT_W-1:0] DIV_ACTIVE;

  int checks = 0;
  int errors = 0;

  // model: divisor in use, captured divisor, pending flag, cycles into period, outputs
  int m_d[N_CH];
  int m_sh[N_CH];
  int m_pos[N_CH];
  bit m_pend[N_CH];
  bit m_tick[N_CH];
  bit m_clk[N_CH];

  clk_tick_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_RESET(DIV_RESET)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .SYNC(SYNC), .DIV_LOAD(DIV_LOAD),
    .DIV_IN(DIV_IN), .TICK(TICK), .CLK_OUT(CLK_OUT), .DIV_ACTIVE(DIV_ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_d[c] = DIV_RESET; m_sh[c] = DIV_RESET; m_pos[c] = 0;
      m_pend[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
    end
  endtask

  task automatic model_edge(input bit en, input bit sync, input bit [N_CH-1:0] ld,
                            input bit [N_CH*CNT_W-1:0] din);
    for (int c = 0; c < N_CH; c++) begin
      int nv;
      bit has_new;
      nv = int'(din[c*CNT_W +: CNT_W]);
      if (ld[c]) begin m_sh[c] = nv; m_pend[c] = 1; end
      has_new = m_pend[c];
      m_tick[c] = 0;
      if (sync) begin
        m_pos[c] = 0; m_clk[c] = 0;
        if (has_new) begin m_d[c] = m_sh[c]; m_pend[c] = 0; end
      end else if (m_d[c] == 0) begin
        m_pos[c] = 0;
        if (ld[c]) begin m_d[c] = nv; m_pend[c] = 0; end
      end else if (en) begin
        if (m_pos[c] + 1 == m_d[c]) begin
          m_pos[c] = 0; m_tick[c] = 1; m_clk[c] = !m_clk[c];
          if (has_new) begin m_d[c] = m_sh[c]; m_pend[c] = 0; end
        end else begin
          m_pos[c]++;
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [N_CH-1:0] et, ec;
    logic [N_CH*CNT_W-1:0] ed;
    for (int c = 0; c < N_CH; c++) begin
      et[c] = m_tick[c];
      ec[c] = m_clk[c];
      ed[c*CNT_W +: CNT_W] = m_d[c][CNT_W-1:0];
    end
    chk({tag, ".tick"}, 32'(TICK), 32'(et));
    chk({tag, ".clk_out"}, 32'(CLK_OUT), 32'(ec));
    chk({tag, ".div_active"}, 32'(DIV_ACTIVE), 32'(ed));
  endtask

  task automatic step(input string tag, input bit en, input bit sync, input bit [1:0] ld,
                      input bit [7:0] d0, input bit [7:0] d1);
    EN = en; SYNC = sync; DIV_LOAD = ld; DIV_IN = {d1, d0};
    @(posedge CLK);
    model_edge(en, sync, ld, {d1, d0});
    #1;
    compare_model(tag);
    SYNC = 1'b0; DIV_LOAD = '0;
  endtask

  initial begin
    RESET = 1'b1; EN = 1'b1; SYNC = 1'b0; DIV_LOAD = '0; DIV_IN = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #2;
    chk("reset.tick", 32'(TICK), 32'h0);
    chk("reset.clk_out", 32'(CLK_OUT), 32'h0);
    chk("reset.div_active", 32'(DIV_ACTIVE), 32'h0404);
    @(negedge CLK);
    RESET = 1'b0;

    // edges 1..12 after release: ticks on 4, 8, 12
    for (int k = 1; k <= 12; k++) begin
      step("start", 1, 0, 2'b00, 0, 0);
      chk("start.tick_edge", 32'(TICK), (k % 4 == 0) ? 32'h3 : 32'h0);
      chk("start.clk_edge", 32'(CLK_OUT), ((k / 4) % 2 == 1) ? 32'h3 : 32'h0);
    end

    // ch0 to 3 loaded at cnt=1; current period finishes at 4
    step("ld3", 1, 0, 2'b00, 0, 0);
    step("ld3", 1, 0, 2'b01, 3, 0);
    for (int k = 0; k < 10; k++) step("ld3", 1, 0, 2'b00, 0, 0);

    // ch1 halts at its next wrap, then 5 takes effect on the load edge
    step("ld0", 1, 0, 2'b10, 0, 0);
    for (int k = 0; k < 8; k++) step("halt", 1, 0, 2'b00, 0, 0);
    step("ld5", 1, 0, 2'b10, 0, 5);
    for (int k = 0; k < 12; k++) step("run5", 1, 0, 2'b00, 0, 0);

    // divisor 1 on ch0, then a 3-cycle EN gap
    step("ld1", 1, 0, 2'b01, 1, 0);
    for (int k = 0; k < 5; k++) step("d1", 1, 0, 2'b00, 0, 0);
    for (int k = 0; k < 3; k++) step("en_off", 0, 0, 2'b00, 0, 0);
    for (int k = 0; k < 4; k++) step("en_on", 1, 0, 2'b00, 0, 0);

    // SYNC with a pending divisor, then SYNC landing on a ch0 wrap edge
    step("ld35", 1, 0, 2'b11, 3, 5);
    for (int k = 0; k < 7; k++) step("pre_sync", 1, 0, 2'b00, 0, 0);
    step("pend2", 1, 0, 2'b10, 0, 2);
    step("sync", 1, 1, 2'b00, 0, 0);
    for (int k = 0; k < 8; k++) step("post_sync", 1, 0, 2'b00, 0, 0);
    for (int k = 0; k < 4 && m_pos[0] + 1 != m_d[0]; k++) step("seek_wrap", 1, 0, 2'b00, 0, 0);
    chk("seek_wrap.found", 32'(m_pos[0] + 1), 32'(m_d[0]));
    step("sync_wrap", 1, 1, 2'b00, 0, 0);
    for (int k = 0; k < 8; k++) step("post_sync2", 1, 0, 2'b00, 0, 0);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      bit en, sy;
      bit [1:0] ld;
      bit [7:0] d0, d1;
      en = ($urandom_range(0, 7) != 0);
      sy = ($urandom_range(0, 24) == 0);
      ld[0] = ($urandom_range(0, 11) == 0);
      ld[1] = ($urandom_range(0, 11) == 0);
      d0 = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 7));
      d1 = 8'($urandom_range(0, 9));
      step("rand", en, sy, ld, d0, d1);
    end

    // async reset between edges with a load pending on ch0
    step("pre_rst", 1, 1, 2'b11, 6, 6);
    step("pre_rst", 1, 0, 2'b00, 0, 0);
    step("pre_rst", 1, 0, 2'b01, 7, 0);
    step("pre_rst", 1, 0, 2'b00, 0, 0);
    #3;
    RESET = 1'b1;
    #1;
    chk("arst.tick", 32'(TICK), 32'h0);
    chk("arst.clk_out", 32'(CLK_OUT), 32'h0);
    chk("arst.div_active", 32'(DIV_ACTIVE), 32'h0404);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
    for (int k = 0; k < 10; k++) step("after_rst", 1, 0, 2'b00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
